int_img_window_reader: RTL and testbench
========================================

// Module: int_img_window_reader
// PURPOSE
// Read-side consumer of the integral / squared-integral image produced upstream.
// - Accepts one window origin (x,y) per request; fetches four corners of both images
//   from a shared synchronous RAM; returns window sum, sum of squares and unnormalised variance.
// - Feeds the cascade classifier's variance normalisation.
// PARAMETERS
// WIDTH_LIMIT   `LAPTOP_WIDTH    image width in pixels
// HEIGHT_LIMIT  `LAPTOP_HEIGHT   image height in pixels
// WIN_SIZE      24               square window edge in pixels
// PORTS
// clock          in   1    single clock, posedge
// reset_n        in   1    asynchronous, active-low reset
// req_valid      in   1    window request valid
// req_ready      out  1    block can accept a request
// req_x          in   $clog2(WIDTH_LIMIT)   window left column
// req_y          in   $clog2(HEIGHT_LIMIT)  window top row
// mem_rd_en      out  1    corner read strobe
// mem_rd_addr    out  $clog2(WIDTH_LIMIT*HEIGHT_LIMIT)  address = row*WIDTH_LIMIT+col
// mem_rd_ii      in   18   integral entry; valid 1 cycle after mem_rd_en
// mem_rd_sq      in   32   squared-integral entry; valid 1 cycle after mem_rd_en
// res_valid      out  1    result valid, held until accepted
// res_ready      in   1    downstream accepts result
// res_sum        out  18   window pixel sum
// res_sq_sum     out  32   window sum of squared pixels
// res_variance   out  36   WIN_SIZE^2*res_sq_sum - res_sum^2
// res_error      out  1    request was out of range; all sums 0
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE. req_ready=1, mem_rd_en=0, mem_rd_addr=0,
//   res_valid=0, all res_* = 0.
// - I[r][c] = inclusive sum over rows 0..r, cols 0..c.
// - With B=y+WIN_SIZE-1, R=x+WIN_SIZE-1:
//   sum = I[B][R] - I[y-1][R] - I[B][x-1] + I[y-1][x-1].
//   Same formula applies to sq.
// - FSM: IDLE -> RD_BR -> RD_TR -> RD_BL -> RD_TL -> LAST -> MUL -> DONE -> IDLE.
//   - IDLE: req_ready=1. On req_valid&&req_ready, latch x,y and go to RD_BR.
//   - RD_*: issue the named corner read. Capture the previous corner's data.
//   - A corner with row -1 or col -1 (y==0 or x==0): mem_rd_en=0 and the term is 0.
//     The state is still visited, so latency is fixed.
//   - LAST: capture TL data. Form res_sum / res_sq_sum in registers.
//   - MUL: register res_variance.
//   - DONE: res_valid=1. Outputs stable until res_ready. On res_valid&&res_ready go to IDLE.
// - Latency: accept edge at cycle 0; res_valid=1 at cycle 7. req_ready=1 again the cycle after result handshake.
// - One request in flight. req_ready=0 in every state except IDLE.
// - Arithmetic widths:
//   - ii add/sub is modulo 2^18; sq add/sub is modulo 2^32. Wrap is harmless because the true window sum fits.
//   - Variance: 36-bit unsigned product/difference. It cannot underflow for valid images.
// - Range check: when x+WIN_SIZE>WIDTH_LIMIT or y+WIN_SIZE>HEIGHT_LIMIT:
//   - no reads are issued (mem_rd_en=0 throughout);
//   - the FSM still walks all states;
//   - DONE shows res_error=1 and all sums 0.
// - res_error=0 for valid requests.
// - reset_n low mid-operation: immediate return to reset values. The request is discarded.
// - mem_rd_addr holds its last value when mem_rd_en=0.
// CONFIGURATION
// WINDOW_VARIANCE_EN defined:
//   - MUL state present; res_variance computed as above; latency 7.
// WINDOW_VARIANCE_EN undefined:
//   - no multiplier; MUL state removed (LAST -> DONE);
//   - res_variance tied to 0; latency 6;
//   - all other behaviour identical.
// TESTING
// - All-ones image (I=(r+1)(c+1), sq identical), req (0,0):
//   - exactly one mem_rd_en pulse, addr=23*W+23;
//   - res_sum=576, res_sq_sum=576, res_variance=0, res_valid at cycle 7.
// - Same image, req (1,1): four reads in order BR,TR,BL,TL:
//   - addrs 24W+24, 0*W+24, 24W+0, 0;
//   - res_sum=576, res_variance=0.
// - 0/2 checkerboard, req (3,5): res_sum=576, res_sq_sum=1152, res_variance=331776.
// - res_ready held 0 for 5 cycles in DONE:
//   - res_* stable, req_ready=0, no new accept;
//   - after handshake, req_ready=1 next cycle.
// - req (WIDTH_LIMIT-23, 0): res_error=1, all sums 0, mem_rd_en never 1, res_valid at cycle 7.
// - reset_n pulsed low during RD_TR:
//   - mem_rd_en and res_valid drop asynchronously;
//   - req_ready=1 after release; the next request completes correctly.

Source files
------------

// File: rtl/int_img_window_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : int_img_window_reader_if
// Description : Bus bundle for the integral-image window reader. Carries the
//               window request handshake, the shared corner-read RAM port and
//               the result handshake.
//   Signals   : req_valid/req_ready/req_x/req_y    - window origin request
//               mem_rd_en/mem_rd_addr              - corner read strobe/address
//               mem_rd_ii/mem_rd_sq                - read data, 1 cycle later
//               res_valid/res_ready                - result handshake
//               res_sum/res_sq_sum/res_variance    - window statistics
//               res_error                          - request was out of range
//   Modports  : slave  - the window reader
//               master - the requester / RAM / consumer side
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 320
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 240
`endif

interface int_img_window_reader_if #(
  parameter int WIDTH_LIMIT  = `LAPTOP_WIDTH,
  parameter int HEIGHT_LIMIT = `LAPTOP_HEIGHT
);
  localparam int c_xw = $clog2(WIDTH_LIMIT);
  localparam int c_yw = $clog2(HEIGHT_LIMIT);
  localparam int c_aw = $clog2(WIDTH_LIMIT * HEIGHT_LIMIT);

  logic            req_valid;
  logic            req_ready;
  logic [c_xw-1:0] req_x;
  logic [c_yw-1:0] req_y;

  logic            mem_rd_en;
  logic [c_aw-1:0] mem_rd_addr;
  logic [17:0]     mem_rd_ii;
  logic [31:0]     mem_rd_sq;

  logic            res_valid;
  logic            res_ready;
  logic [17:0]     res_sum;
  logic [31:0]     res_sq_sum;
  logic [35:0]     res_variance;
  logic            res_error;

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_ii, mem_rd_sq,
    output res_valid,
    input  res_ready,
    output res_sum, res_sq_sum, res_variance, res_error
  );

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_ii, mem_rd_sq,
    input  res_valid,
    output res_ready,
    input  res_sum, res_sq_sum, res_variance, res_error
  );
endinterface

`default_nettype wire

// File: rtl/int_img_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : int_img_window_reader
// Description : Read-side consumer of the integral and squared-integral image.
//               For each window origin (x,y) it reads the four window corners
//               (BR, TR, BL, TL) from a shared synchronous RAM and returns the
//               window pixel sum, sum of squares and unnormalised variance
//               WIN_SIZE^2*sq_sum - sum^2.
//   Ports     : clock   - single clock, rising edge
//               reset_n - asynchronous active-low reset
//               bus     - int_img_window_reader_if.slave (request, RAM read
//                         port and result handshake)
//   Option    : WINDOW_VARIANCE_EN - when defined, a MUL state computes the
//               variance (latency 7); when undefined the multiplier and MUL
//               state are absent, res_variance is 0 (latency 6).
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 320
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 240
`endif

module int_img_window_reader #(
  parameter int WIDTH_LIMIT  = `LAPTOP_WIDTH,
  parameter int HEIGHT_LIMIT = `LAPTOP_HEIGHT,
  parameter int WIN_SIZE     = 24
) (
  input wire                      clock,
  input wire                      reset_n,
  int_img_window_reader_if.slave  bus
);

  localparam int c_xw = $clog2(WIDTH_LIMIT);
  localparam int c_yw = $clog2(HEIGHT_LIMIT);
  localparam int c_aw = $clog2(WIDTH_LIMIT * HEIGHT_LIMIT);

  typedef logic [c_aw-1:0] addr_t;

`ifdef WINDOW_VARIANCE_EN
  typedef enum logic [2:0] {
    S_IDLE, S_RD_BR, S_RD_TR, S_RD_BL, S_RD_TL, S_LAST, S_MUL, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_RD_BR, S_RD_TR, S_RD_BL, S_RD_TL, S_LAST, S_DONE
  } state_t;
`endif

  state_t          state_q, state_d;

  logic [c_xw-1:0] x_q;
  logic [c_yw-1:0] y_q;
  logic            err_q;
  logic            rd_issued_q;   // a read was issued last cycle: RAM data is live
  addr_t           addr_q;

  logic [17:0]     ii_br_q, ii_tr_q, ii_bl_q;
  logic [31:0]     sq_br_q, sq_tr_q, sq_bl_q;
  logic [17:0]     sum_q;
  logic [31:0]     sq_sum_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic            w_accept;
  logic            w_req_oob;
  logic            w_rd_en;
  addr_t           w_corner;
  addr_t           w_rd_addr;
  logic            w_req_ready;
  logic            w_res_valid;
  logic [17:0]     w_term_ii;
  logic [31:0]     w_term_sq;

  addr_t           w_x_ext, w_y_ext;
  addr_t           w_top, w_bot, w_left, w_right;
  addr_t           w_addr_br, w_addr_tr, w_addr_bl, w_addr_tl;
  logic            w_x_nz, w_y_nz;

  assign w_accept  = (state_q == S_IDLE) && bus.req_valid;

  // Range check done on the incoming request in 32-bit so x+WIN_SIZE cannot wrap.
  assign w_req_oob = ((32'(bus.req_x) + 32'(WIN_SIZE)) > 32'(WIDTH_LIMIT)) ||
                     ((32'(bus.req_y) + 32'(WIN_SIZE)) > 32'(HEIGHT_LIMIT));

  assign w_x_ext  = addr_t'(x_q);
  assign w_y_ext  = addr_t'(y_q);
  assign w_x_nz   = (x_q != '0);
  assign w_y_nz   = (y_q != '0);

  // Row/col of the corner just outside the window on the top/left side. When
  // x or y is 0 these wrap, but the matching read is suppressed.
  assign w_top    = w_y_ext - addr_t'(1);
  assign w_left   = w_x_ext - addr_t'(1);
  assign w_bot    = w_y_ext + addr_t'(WIN_SIZE - 1);
  assign w_right  = w_x_ext + addr_t'(WIN_SIZE - 1);

  assign w_addr_br = w_bot * addr_t'(WIDTH_LIMIT) + w_right;
  assign w_addr_tr = w_top * addr_t'(WIDTH_LIMIT) + w_right;
  assign w_addr_bl = w_bot * addr_t'(WIDTH_LIMIT) + w_left;
  assign w_addr_tl = w_top * addr_t'(WIDTH_LIMIT) + w_left;

  // Suppressed reads contribute a zero term; this also makes error results 0.
  assign w_term_ii = rd_issued_q ? bus.mem_rd_ii : 18'd0;
  assign w_term_sq = rd_issued_q ? bus.mem_rd_sq : 32'd0;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    w_req_ready = 1'b0;
    w_res_valid = 1'b0;
    w_rd_en     = 1'b0;
    w_corner    = addr_q;

    case (state_q)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          state_d = S_RD_BR;
        end
      end
      S_RD_BR: begin
        w_rd_en  = !err_q;
        w_corner = w_addr_br;
        state_d  = S_RD_TR;
      end
      S_RD_TR: begin
        w_rd_en  = !err_q && w_y_nz;
        w_corner = w_addr_tr;
        state_d  = S_RD_BL;
      end
      S_RD_BL: begin
        w_rd_en  = !err_q && w_x_nz;
        w_corner = w_addr_bl;
        state_d  = S_RD_TL;
      end
      S_RD_TL: begin
        w_rd_en  = !err_q && w_x_nz && w_y_nz;
        w_corner = w_addr_tl;
        state_d  = S_LAST;
      end
      S_LAST: begin
`ifdef WINDOW_VARIANCE_EN
        state_d = S_MUL;
`else
        state_d = S_DONE;
`endif
      end
`ifdef WINDOW_VARIANCE_EN
      S_MUL: begin
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The address bus only moves on an actual read; otherwise it holds.
    w_rd_addr = w_rd_en ? w_corner : addr_q;
  end

  // --------------------------------------------------------------------------
  // Datapath: request latch, corner capture, sum formation
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      rd_issued_q <= 1'b0;
      addr_q      <= '0;
      ii_br_q     <= '0;
      ii_tr_q     <= '0;
      ii_bl_q     <= '0;
      sq_br_q     <= '0;
      sq_tr_q     <= '0;
      sq_bl_q     <= '0;
      sum_q       <= '0;
      sq_sum_q    <= '0;
    end else begin
      rd_issued_q <= w_rd_en;
      addr_q      <= w_rd_addr;

      if (w_accept) begin
        x_q   <= bus.req_x;
        y_q   <= bus.req_y;
        err_q <= w_req_oob;
      end

      // Each read state captures the data of the read issued one state earlier.
      case (state_q)
        S_RD_TR: begin
          ii_br_q <= w_term_ii;
          sq_br_q <= w_term_sq;
        end
        S_RD_BL: begin
          ii_tr_q <= w_term_ii;
          sq_tr_q <= w_term_sq;
        end
        S_RD_TL: begin
          ii_bl_q <= w_term_ii;
          sq_bl_q <= w_term_sq;
        end
        S_LAST: begin
          // Modulo arithmetic: intermediate wrap cancels since the window sum fits.
          sum_q    <= ii_br_q - ii_tr_q - ii_bl_q + w_term_ii;
          sq_sum_q <= sq_br_q - sq_tr_q - sq_bl_q + w_term_sq;
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Variance
  // --------------------------------------------------------------------------
`ifdef WINDOW_VARIANCE_EN
  localparam logic [35:0] c_win_sq = 36'(WIN_SIZE * WIN_SIZE);

  logic [35:0] var_q;
  logic [35:0] w_sum_ext;

  assign w_sum_ext = 36'(sum_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      var_q <= '0;
    end else if (state_q == S_MUL) begin
      var_q <= c_win_sq * 36'(sq_sum_q) - w_sum_ext * w_sum_ext;
    end
  end

  assign bus.res_variance = var_q;
`else
  assign bus.res_variance = 36'd0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready   = w_req_ready;
  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_rd_addr = w_rd_addr;
  assign bus.res_valid   = w_res_valid;
  assign bus.res_sum     = sum_q;
  assign bus.res_sq_sum  = sq_sum_q;
  assign bus.res_error   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_int_img_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_img_window_reader
// Description : Self-checking bench for int_img_window_reader. Holds a pixel
//               image, derives the integral images served by a synchronous RAM
//               model, and checks every result against window sums computed
//               directly from the pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_img_window_reader;

  localparam int W   = 40;
  localparam int H   = 32;
  localparam int WIN = 24;
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);
`ifdef WINDOW_VARIANCE_EN
  localparam int EXP_LAT = 7;
  localparam bit VAR_ON  = 1'b1;
`else
  localparam int EXP_LAT = 6;
  localparam bit VAR_ON  = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int_img_window_reader_if #(.WIDTH_LIMIT(W), .HEIGHT_LIMIT(H)) bus ();

  int_img_window_reader #(
    .WIDTH_LIMIT (W),
    .HEIGHT_LIMIT(H),
    .WIN_SIZE    (WIN)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int          pix    [W*H];
  logic [17:0] ii_mem [W*H];
  logic [31:0] sq_mem [W*H];

  int n_checks = 0;
  int n_fail   = 0;

  // Synchronous RAM: data appears one cycle after the read strobe.
  always @(posedge clock) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_ii <= ii_mem[int'(bus.mem_rd_addr)];
      bus.mem_rd_sq <= sq_mem[int'(bus.mem_rd_addr)];
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // kind 0: all ones, 1: 0/2 checkerboard, 2: random 0..255
  task automatic load_image(input int kind);
    int s, q;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (kind == 0)      pix[r*W+c] = 1;
        else if (kind == 1) pix[r*W+c] = (((r + c) % 2) != 0) ? 2 : 0;
        else                pix[r*W+c] = int'($urandom_range(0, 255));
      end
    end
    // I[r][c] by direct inclusive summation, stored modulo the entry width.
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        s = 0; q = 0;
        for (int rr = 0; rr <= r; rr++) begin
          for (int cc = 0; cc <= c; cc++) begin
            s += pix[rr*W+cc];
            q += pix[rr*W+cc] * pix[rr*W+cc];
          end
        end
        ii_mem[r*W+c] = 18'(s);
        sq_mem[r*W+c] = 32'(q);
      end
    end
  endtask

  task automatic run_req(input string name, input int x, input int y, input int hold);
    longint exp_sum, exp_sq, exp_var;
    bit     oob, seen, bad_rdy;
    int     lat, n_cmp;
    int     exp_addr[$];
    int     got_addr[$];

    oob = (x + WIN > W) || (y + WIN > H);
    exp_sum = 0; exp_sq = 0;
    if (!oob) begin
      for (int r = y; r < y + WIN; r++) begin
        for (int c = x; c < x + WIN; c++) begin
          exp_sum += pix[r*W+c];
          exp_sq  += pix[r*W+c] * pix[r*W+c];
        end
      end
      exp_addr.push_back((y + WIN - 1) * W + x + WIN - 1);
      if (y > 0)          exp_addr.push_back((y - 1) * W + x + WIN - 1);
      if (x > 0)          exp_addr.push_back((y + WIN - 1) * W + x - 1);
      if (x > 0 && y > 0) exp_addr.push_back((y - 1) * W + x - 1);
    end
    exp_var = VAR_ON ? ((longint'(WIN * WIN) * exp_sq - exp_sum * exp_sum) & 64'hF_FFFF_FFFF) : 0;

    @(negedge clock);
    check_val({name, "/req_ready_idle"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_x     = XW'(x);
    bus.req_y     = YW'(y);
    bus.res_ready = 1'b0;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;

    seen = 1'b0; lat = 0; bad_rdy = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clock);
      if (bus.mem_rd_en) got_addr.push_back(int'(bus.mem_rd_addr));
      if (bus.req_ready) bad_rdy = 1'b1;
      if (bus.res_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check_val({name, "/latency"}, 64'(lat), 64'(EXP_LAT));
    check_val({name, "/req_ready_busy"}, 64'(bad_rdy), 64'd0);
    check_val({name, "/n_reads"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    n_cmp = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int k = 0; k < n_cmp; k++) begin
      check_val($sformatf("%s/rd_addr%0d", name, k), 64'(got_addr[k]), 64'(exp_addr[k]));
    end

    if (seen) begin
      for (int h = 0; h <= hold; h++) begin
        if (h == 0 || h == hold) begin
          check_val({name, "/res_sum"},   64'(bus.res_sum),      64'(exp_sum));
          check_val({name, "/res_sq"},    64'(bus.res_sq_sum),   64'(exp_sq));
          check_val({name, "/res_var"},   64'(bus.res_variance), 64'(exp_var));
          check_val({name, "/res_error"}, 64'(bus.res_error),    64'(oob));
        end
        if (h > 0) begin
          check_val({name, "/hold_valid"}, 64'(bus.res_valid), 64'd1);
          check_val({name, "/hold_ready"}, 64'(bus.req_ready), 64'd0);
        end
        if (h < hold) begin
          bus.req_valid = 1'b1;   // must not be accepted while a result is pending
          @(negedge clock);
          if (bus.mem_rd_en) got_addr.push_back(int'(bus.mem_rd_addr));
        end
      end
      bus.req_valid = 1'b0;
      check_val({name, "/hold_no_reads"}, 64'(got_addr.size()), 64'(exp_addr.size()));
      bus.res_ready = 1'b1;
      @(posedge clock);
      #1 bus.res_ready = 1'b0;
      @(negedge clock);
      check_val({name, "/post_req_ready"}, 64'(bus.req_ready), 64'd1);
      check_val({name, "/post_res_valid"}, 64'(bus.res_valid), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.res_ready = 1'b0;
    bus.mem_rd_ii = '0;
    bus.mem_rd_sq = '0;
    load_image(0);

    repeat (3) @(negedge clock);
    check_val("rst/req_ready", 64'(bus.req_ready),    64'd1);
    check_val("rst/rd_en",     64'(bus.mem_rd_en),    64'd0);
    check_val("rst/rd_addr",   64'(bus.mem_rd_addr),  64'd0);
    check_val("rst/res_valid", 64'(bus.res_valid),    64'd0);
    check_val("rst/res_sum",   64'(bus.res_sum),      64'd0);
    check_val("rst/res_sq",    64'(bus.res_sq_sum),   64'd0);
    check_val("rst/res_var",   64'(bus.res_variance), 64'd0);
    check_val("rst/res_error", 64'(bus.res_error),    64'd0);
    reset_n = 1'b1;

    run_req("ones_0_0", 0, 0, 0);
    run_req("ones_1_1", 1, 1, 0);
    run_req("ones_max", W - WIN, H - WIN, 1);

    load_image(1);
    run_req("chk_3_5", 3, 5, 5);

    run_req("oob_x", W - 23, 0, 0);
    run_req("oob_y", 2, H - 20, 2);

    // Asynchronous reset while the TR corner read is on the bus.
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_x     = XW'(2);
    bus.req_y     = YW'(3);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_val("arst/rd_en_before", 64'(bus.mem_rd_en), 64'd1);
    reset_n = 1'b0;
    #1;
    check_val("arst/rd_en",     64'(bus.mem_rd_en),   64'd0);
    check_val("arst/res_valid", 64'(bus.res_valid),   64'd0);
    check_val("arst/rd_addr",   64'(bus.mem_rd_addr), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_val("arst/req_ready", 64'(bus.req_ready), 64'd1);
    run_req("after_rst", 4, 2, 0);

    load_image(2);
    for (int t = 0; t < 14; t++) begin
      run_req($sformatf("rnd%0d", t),
              int'($urandom_range(0, W - WIN + 2)),
              int'($urandom_range(0, H - WIN + 2)),
              int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
